// File: rtl/hazard_pkg.sv
// Shared types and encodings for the hazard / flush control block.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    BFLUSH = 2'd2
  } hz_state_t;

  // Forwarding mux select encodings for the EX operands.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Width of the stall/flush window down-counter.
  localparam int unsigned HZ_CNT_W = 3;

endpackage

// File: rtl/fwd_select.sv
// Picks the freshest producer of one EX source operand; MEM is younger than WB so it wins.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs_i,
  input  logic [ADDR_W-1:0] rd_mem_i,
  input  logic              reg_write_mem_i,
  input  logic [ADDR_W-1:0] rd_wb_i,
  input  logic              reg_write_wb_i,
  output logic [1:0]        sel_o
);

  // Priority compare; x0 is never a forwarding source.
  always_comb begin
    sel_o = FWD_RF;
    if (reg_write_mem_i && (rd_mem_i != '0) && (rd_mem_i == rs_i)) begin
      sel_o = FWD_MEM;
    end else if (reg_write_wb_i && (rd_wb_i != '0) && (rd_wb_i == rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_flush_unit.sv
// Forwarding selects, load-use stalls, redirect flush and wrong-path squash window.
module hazard_flush_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned LOAD_STALLS  = 1,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  uses_rs2_id,
  input  logic [REG_ADDR_W-1:0] rs1_ex,
  input  logic [REG_ADDR_W-1:0] rs2_ex,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  mem_read_ex,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  reg_write_mem,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  reg_write_wb,
  input  logic                  pc_sel_wb,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  bubble_idex,
  output logic                  flush_front,
  output logic                  squash,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  hz_state_t             state_q, state_d;
  logic [HZ_CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic [1:0]            fwd_a_raw, fwd_b_raw;
  logic                  load_use;
  logic                  stall_c, flush_c, squash_c, fwd_kill_c;

  fwd_select #(.ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_i            (rs1_ex),
    .rd_mem_i        (rd_mem),
    .reg_write_mem_i (reg_write_mem),
    .rd_wb_i         (rd_wb),
    .reg_write_wb_i  (reg_write_wb),
    .sel_o           (fwd_a_raw)
  );

  fwd_select #(.ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_i            (rs2_ex),
    .rd_mem_i        (rd_mem),
    .reg_write_mem_i (reg_write_mem),
    .rd_wb_i         (rd_wb),
    .reg_write_wb_i  (reg_write_wb),
    .sel_o           (fwd_b_raw)
  );

  assign load_use = mem_read_ex && (rd_ex != '0) &&
                    ((rd_ex == rs1_id) || (uses_rs2_id && (rd_ex == rs2_id)));

  // Next-state and control decode; a redirect always beats a pending or new stall.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    flush_c    = 1'b0;
    squash_c   = 1'b0;
    fwd_kill_c = 1'b0;
    unique case (state_q)
      RUN: begin
        if (pc_sel_wb) begin
          flush_c = 1'b1;
          state_d = BFLUSH;
          cnt_d   = HZ_CNT_W'(FLUSH_CYCLES - 1);
        end else if (load_use) begin
          stall_c = 1'b1;
          if (LOAD_STALLS > 1) begin
            state_d = LSTALL;
            cnt_d   = HZ_CNT_W'(LOAD_STALLS - 1);
          end
        end
      end
      LSTALL: begin
        if (pc_sel_wb) begin
          flush_c = 1'b1;
          state_d = BFLUSH;
          cnt_d   = HZ_CNT_W'(FLUSH_CYCLES - 1);
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - HZ_CNT_W'(1);
          if (cnt_q <= HZ_CNT_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      BFLUSH: begin
        squash_c   = 1'b1;
        fwd_kill_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - HZ_CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_c && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State, window counter and performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Input-driven controls are gated by reset so they drop the moment reset asserts.
  assign stall_pc    = stall_c & reset_n;
  assign stall_ifid  = stall_c & reset_n;
  assign bubble_idex = stall_c & reset_n;
  assign flush_front = flush_c & reset_n;
  assign squash      = squash_c;
  assign fwd_a_sel   = fwd_kill_c ? FWD_RF : fwd_a_raw;
  assign fwd_b_sel   = fwd_kill_c ? FWD_RF : fwd_b_raw;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
